pcm_to_i2s: RTL
===============

# pcm_to_i2s

Serialises parallel left/right PCM samples into an I2S stream (word select + serial data), one bit per `clk` cycle. It is the transmit-side counterpart of the I2S receive path in the beamformer. It lets the design drive a DAC or loop its beamformed output back into the receive buffers for self-test. Samples enter through a single-entry valid/ready holding register and are loaded once per frame. A missing sample produces a zero frame and an underrun indication.

## Interface
- `NUMBER_OF_BITS`, 16: PCM sample width per channel.
- `SLOT_BITS`, 32: clock cycles per half-frame (ws phase). Must satisfy `SLOT_BITS >= NUMBER_OF_BITS+1`. Frame length F = 2*SLOT_BITS.

- `clk` input 1: bit clock. All state updates on posedge.
- `reset` input 1: asynchronous, active-high.
- `enable` input 1: run request, sampled only at frame boundaries.
- `pcm_left` input NUMBER_OF_BITS: left sample, two's complement.
- `pcm_right` input NUMBER_OF_BITS: right sample.
- `in_valid` input 1: sample pair offered.
- `in_ready` output 1: holding register can accept; reset 1.
- `ws` output 1: word select, 0 = left, 1 = right; reset 1.
- `sd` output 1: serial data, MSB first; reset 0.
- `underrun` output 1: one-cycle pulse, frame sent without fresh data; reset 0.
- `underrun_count` output 8: saturating count of underruns; reset 0.

## Operation
- The block has two states, IDLE and RUN. Reset enters IDLE with frame counter `k = F-1`.
- Handshake:
  - Transfer occurs when `in_valid && in_ready`. Transfer sets `hold_full` and captures both samples.
  - `in_ready = !hold_full`, taken from a register. There is no combinational path from `in_valid`.
- Load event, `load_now = enable && (IDLE || (RUN && k == F-1))`:
  - If `hold_full`: copy hold into the left/right shift registers and clear `hold_full`.
  - Else: load zeros into both shift registers, pulse `underrun`, and increment `underrun_count`, saturating at 255.
  - After either case: state becomes RUN and `k` becomes 0 on the next edge.
- Stopping: in RUN at `k == F-1` with `enable == 0`, the block enters IDLE with no load and no underrun.
- In IDLE: `ws = 1`, `sd = 0`, and `k` holds. The holding register still accepts data.
- In frame cycle k (k = 0..F-1) of RUN, outputs are driven from registers:
  - `ws = (k >= SLOT_BITS)`.
  - `sd = left[NUMBER_OF_BITS-k]` for 1 <= k <= NUMBER_OF_BITS. This is the one-bit I2S delay: the MSB goes out one cycle after `ws` falls.
  - `sd = right[NUMBER_OF_BITS-(k-SLOT_BITS)]` for SLOT_BITS+1 <= k <= SLOT_BITS+NUMBER_OF_BITS.
  - `sd = 0` in all other cycles (delay bit and padding).
- Boundary cases:
  - A transfer that lands in the same cycle as `load_now` with `hold_full == 0` is not used for that frame. That frame underruns, and the data is held for the next frame.
  - Holding-register overrun cannot occur, because `in_ready` is low while the register is full.
  - `enable` changes mid-frame have no effect until `k == F-1`.
- Asynchronous reset mid-frame: all outputs take their reset values immediately. Hold and shift contents are discarded.

## Timing
- Latency from transfer to MSB on `sd` is at least 2 cycles (accept edge, then load edge, then `k = 1`). The maximum is F+1 cycles when the transfer misses a load.
- `in_ready` returns to 1 on the clock after `load_now` consumes the hold.
- `underrun` is high for exactly the cycle where k = 0 of the zero frame.
- Sustained throughput is one sample pair per F cycles. Continuous streaming requires the producer to refill within F-1 cycles of `in_ready` rising.
- `ws` has a 50 % duty cycle with period F. There are no glitches, because `ws` and `sd` come straight from flops.
- Downstream receivers sample `sd`/`ws` on the opposite `clk` edge or one cycle later.

## Test plan
- Reset, then `enable = 1` with hold empty:
  - First frame carries `sd` all 0 and `underrun` pulses at k = 0.
  - `underrun_count = 1`.
  - `ws` is low for 32 cycles, then high for 32 cycles.
- Preload L = 0xA5C3, R = 0x8001, then `enable = 1`:
  - `sd` at k = 1..16 equals 1010010111000011.
  - `sd` at k = 33..48 equals 1000000000000001.
  - All other bits are 0, and there is no underrun.
- Streaming: feed a new pair each time `in_ready` rises, for 10 frames. Expect no underrun, and every frame decoded by the I2S receiver matches its input exactly.
- Late producer: offer data in the cycle of `load_now` while hold is empty. That frame is zero with `underrun = 1`, and the next frame carries the data.
- Drop `enable` at k = 10:
  - The frame completes, then `ws` stays 1 and `sd` stays 0.
  - `underrun_count` is unchanged.
  - Re-enable and the next frame starts at k = 0 with the held data.
- Assert `reset` at k = 20: `ws = 1`, `sd = 0`, `in_ready = 1`, and `underrun_count = 0` immediately. After 300 forced underruns, `underrun_count` reads 255.

Source files
------------

// File: rtl/pcm_to_i2s.sv
// pcm_to_i2s: serialises left/right PCM pairs into an I2S stream, one bit per clk,
// through a single-entry valid/ready holding register loaded once per frame.
module pcm_to_i2s #(
  parameter int NUMBER_OF_BITS = 16,
  parameter int SLOT_BITS      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUMBER_OF_BITS-1:0] pcm_left,
  input  logic [NUMBER_OF_BITS-1:0] pcm_right,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      ws,
  output logic                      sd,
  output logic                      underrun,
  output logic [7:0]                underrun_count
);
  localparam int F  = 2 * SLOT_BITS;
  localparam int KW = $clog2(F);
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;
  localparam logic [KW-1:0] K_LAST = KW'(F - 1);
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [KW-1:0] K_NB   = KW'(NUMBER_OF_BITS);
  localparam logic [KW-1:0] K_S    = KW'(SLOT_BITS);
  localparam logic [KW-1:0] K_S1   = KW'(SLOT_BITS + 1);
  localparam logic [KW-1:0] K_SN   = KW'(SLOT_BITS + NUMBER_OF_BITS);
  logic                      state, state_n, last, load_now, shl_on, shr_on, ws_n, sd_n, hold_full;
  logic [KW-1:0]             k, k_n;
  logic [NUMBER_OF_BITS-1:0] hold_l, hold_r, sh_l, sh_r;
  assign in_ready = ~hold_full;
  // Outputs are precomputed for the next k so ws/sd leave the block straight from flops.
  always_comb begin
    last     = state == RUN && k == K_LAST;
    load_now = enable && (state == IDLE || last);
    state_n  = load_now ? RUN : last ? IDLE : state;
    k_n      = load_now ? '0 : (state == RUN && !last) ? k + K_ONE : k;
    shl_on   = state_n == RUN && k_n >= K_ONE && k_n <= K_NB;
    shr_on   = state_n == RUN && k_n >= K_S1 && k_n <= K_SN;
    ws_n     = state_n == IDLE || k_n >= K_S;
    sd_n     = shl_on ? sh_l[NUMBER_OF_BITS-1] : shr_on ? sh_r[NUMBER_OF_BITS-1] : 1'b0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      k              <= K_LAST;
      hold_full      <= 1'b0;
      hold_l         <= '0;
      hold_r         <= '0;
      sh_l           <= '0;
      sh_r           <= '0;
      ws             <= 1'b1;
      sd             <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      ws        <= ws_n;
      sd        <= sd_n;
      underrun  <= load_now && !hold_full;
      hold_full <= hold_full ? !load_now : in_valid;
      if (load_now && !hold_full && underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
      if (in_valid && !hold_full) begin
        hold_l <= pcm_left;
        hold_r <= pcm_right;
      end
      if (load_now) sh_l <= hold_full ? hold_l : '0;
      else if (shl_on) sh_l <= sh_l << 1;
      if (load_now) sh_r <= hold_full ? hold_r : '0;
      else if (shr_on) sh_r <= sh_r << 1;
    end
  end
endmodule
